// File: rtl/fifo_fwft_wm.sv
`default_nettype none
// ============================================================================
// Module   : fifo_fwft_wm
// Desc     : FWFT FIFO with registered output stage, almost flags, flush and
//            peak-occupancy watermark.
// Revision : 1.0
// ============================================================================
module fifo_fwft_wm #(
  parameter int WIDTH         = 16,
  parameter int DEPTH         = 256,
  parameter int ADDR_BITS     = $clog2(DEPTH),
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                 CLK_IN,
  input  logic                 RESET_IN,
  input  logic                 FLUSH_IN,
  input  logic                 CLR_PEAK_IN,
  input  logic [WIDTH-1:0]     DIN,
  input  logic                 DIN_VALID,
  output logic                 DIN_READY,
  output logic [WIDTH-1:0]     DOUT,
  output logic                 DOUT_VALID,
  input  logic                 DOUT_READY,
  output logic [ADDR_BITS:0]   level,
  output logic                 ALMOST_FULL,
  output logic                 ALMOST_EMPTY,
  output logic [ADDR_BITS:0]   PEAK_LEVEL
);

  localparam logic [ADDR_BITS:0] c_DEPTH  = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] c_AFULL  = (ADDR_BITS+1)'(AFULL_THRESH);
  localparam logic [ADDR_BITS:0] c_AEMPTY = (ADDR_BITS+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [ADDR_BITS-1:0] r_wr_ptr;
  logic [ADDR_BITS-1:0] r_rd_ptr;
  logic [ADDR_BITS:0]   r_level;
  logic [ADDR_BITS:0]   r_peak;
  logic [WIDTH-1:0]     r_dout;
  logic                 r_dout_valid;
  logic                 r_din_ready;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_stor_empty;
  logic                 w_load_din;
  logic                 w_load_mem;
  logic                 w_mem_wr;
  logic [ADDR_BITS:0]   w_next_level;

  assign w_push       = DIN_VALID && r_din_ready;
  assign w_pop        = r_dout_valid && DOUT_READY;
  assign w_stor_empty = (r_level == {{ADDR_BITS{1'b0}}, r_dout_valid});

  // Output register takes DIN when it is (or is about to be) empty and
  // storage has nothing queued ahead of the incoming word.
  assign w_load_din   = w_push && (!r_dout_valid || (w_pop && w_stor_empty));
  assign w_load_mem   = w_pop && !w_stor_empty;
  assign w_mem_wr     = w_push && !w_load_din && RESET_IN && !FLUSH_IN;
  assign w_next_level = r_level + {{ADDR_BITS{1'b0}}, w_push}
                                - {{ADDR_BITS{1'b0}}, w_pop};

  always_ff @(posedge CLK_IN) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= DIN;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_peak       <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_din_ready  <= 1'b0;
    end else if (FLUSH_IN) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_dout_valid <= 1'b0;
      r_din_ready  <= 1'b1;
    end else begin
      r_level     <= w_next_level;
      r_din_ready <= (w_next_level < c_DEPTH);
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_load_din) begin
        r_dout       <= DIN;
        r_dout_valid <= 1'b1;
      end else if (w_load_mem) begin
        r_dout       <= r_mem[r_rd_ptr];
        r_dout_valid <= 1'b1;
        r_rd_ptr     <= r_rd_ptr + 1'b1;
      end else if (w_pop) begin
        r_dout_valid <= 1'b0;
      end
      if (CLR_PEAK_IN || (w_next_level > r_peak)) begin
        r_peak <= w_next_level;
      end
    end
  end

  assign DIN_READY    = r_din_ready;
  assign DOUT         = r_dout;
  assign DOUT_VALID   = r_dout_valid;
  assign level        = r_level;
  assign PEAK_LEVEL   = r_peak;
  assign ALMOST_FULL  = (r_level >= c_AFULL);
  assign ALMOST_EMPTY = (r_level <= c_AEMPTY);

endmodule
`default_nettype wire

// File: tb/tb_fifo_fwft_wm.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_fwft_wm
// Desc     : Directed self-checking bench for fifo_fwft_wm (DEPTH=16).
// Revision : 1.0
// ============================================================================
module tb_fifo_fwft_wm;

  localparam int c_WIDTH = 16;
  localparam int c_DEPTH = 16;
  localparam int c_AB    = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               clr_peak;
  logic [c_WIDTH-1:0] din;
  logic               din_valid;
  logic               din_ready;
  logic [c_WIDTH-1:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic [c_AB:0]      lvl;
  logic               afull;
  logic               aempty;
  logic [c_AB:0]      peak;

  int n_pass  = 0;
  int n_total = 0;
  logic [15:0] mq[$];

  always #5 clk = ~clk;

  fifo_fwft_wm #(
    .WIDTH(c_WIDTH), .DEPTH(c_DEPTH), .AFULL_THRESH(12), .AEMPTY_THRESH(2)
  ) u_dut (
    .CLK_IN(clk), .RESET_IN(rst_n), .FLUSH_IN(flush), .CLR_PEAK_IN(clr_peak),
    .DIN(din), .DIN_VALID(din_valid), .DIN_READY(din_ready),
    .DOUT(dout), .DOUT_VALID(dout_valid), .DOUT_READY(dout_ready),
    .level(lvl), .ALMOST_FULL(afull), .ALMOST_EMPTY(aempty), .PEAK_LEVEL(peak)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [15:0] w);
    din = w; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; clr_peak = 1'b0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    tick(); tick();
    check_eq("rst_level", 32'(lvl), 0);
    check_eq("rst_dvalid", 32'(dout_valid), 0);
    check_eq("rst_dout", 32'(dout), 0);
    check_eq("rst_din_ready", 32'(din_ready), 0);
    check_eq("rst_peak", 32'(peak), 0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_rst", 32'(din_ready), 1);

    // Single word latency
    push_one(16'hAAAA);
    check_eq("single_valid", 32'(dout_valid), 1);
    check_eq("single_dout", 32'(dout), 32'hAAAA);
    check_eq("single_level", 32'(lvl), 1);
    check_eq("single_aempty", 32'(aempty), 1);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;
    check_eq("single_pop_valid", 32'(dout_valid), 0);
    check_eq("single_pop_level", 32'(lvl), 0);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      push_one(16'(i));
      check_eq("fill_afull", 32'(afull), (i + 1 >= 12) ? 1 : 0);
      check_eq("fill_aempty", 32'(aempty), (i + 1 <= 2) ? 1 : 0);
    end
    check_eq("full_level", 32'(lvl), 16);
    check_eq("full_ready", 32'(din_ready), 0);
    push_one(16'h0099);
    check_eq("full_reject_level", 32'(lvl), 16);
    check_eq("full_peak", 32'(peak), 16);
    dout_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("drain_valid", 32'(dout_valid), 1);
      check_eq("drain_dout", 32'(dout), i);
      tick();
    end
    dout_ready = 1'b0;
    check_eq("drain_end_valid", 32'(dout_valid), 0);
    check_eq("drain_end_level", 32'(lvl), 0);
    check_eq("drain_peak", 32'(peak), 16);

    // Full with simultaneous push and pop
    for (int i = 0; i < 16; i++) push_one(16'(16'h0100 + i));
    din = 16'hBEEF; din_valid = 1'b1; dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    check_eq("fullpp_level", 32'(lvl), 15);
    check_eq("fullpp_ready", 32'(din_ready), 1);
    tick();
    din_valid = 1'b0;
    check_eq("fullpp_accept_level", 32'(lvl), 16);
    dout_ready = 1'b1;
    for (int i = 1; i < 17; i++) begin
      check_eq("fullpp_drain", 32'(dout), (i == 16) ? 32'hBEEF : 32'h0100 + i);
      tick();
    end
    dout_ready = 1'b0;
    check_eq("fullpp_empty", 32'(lvl), 0);

    // Bypass at level 1
    push_one(16'h1111);
    din = 16'h2222; din_valid = 1'b1; dout_ready = 1'b1;
    tick();
    din_valid = 1'b0; dout_ready = 1'b0;
    check_eq("bypass_level", 32'(lvl), 1);
    check_eq("bypass_valid", 32'(dout_valid), 1);
    check_eq("bypass_dout", 32'(dout), 32'h2222);
    dout_ready = 1'b1; tick(); dout_ready = 1'b0;

    // Wrap-around with interleaved traffic; watermark cleared first
    clr_peak = 1'b1; tick(); clr_peak = 1'b0;
    check_eq("clr_peak_empty", 32'(peak), 0);
    for (int i = 0; i < 9; i++) begin
      mq.push_back(16'(16'h5000 + i));
      push_one(16'(16'h5000 + i));
    end
    check_eq("wrap_aempty_hi", 32'(aempty), 0);
    for (int i = 9; i < 40; i++) begin
      check_eq("wrap_dout", 32'(dout), 32'(mq.pop_front()));
      mq.push_back(16'(16'h5000 + i));
      din = 16'(16'h5000 + i); din_valid = 1'b1; dout_ready = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    check_eq("wrap_level9", 32'(lvl), 9);
    for (int i = 0; i < 4; i++) begin
      check_eq("wrap_dout", 32'(dout), 32'(mq.pop_front()));
      tick();
    end
    dout_ready = 1'b0;
    check_eq("wrap_peak", 32'(peak), 9);
    clr_peak = 1'b1; tick(); clr_peak = 1'b0;
    check_eq("clr_peak_lvl5", 32'(peak), 5);
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_eq("wrap_dout", 32'(dout), 32'(mq.pop_front()));
      tick();
    end
    dout_ready = 1'b0;
    check_eq("wrap_empty_valid", 32'(dout_valid), 0);

    // Flush with concurrent push
    for (int i = 0; i < 7; i++) push_one(16'(16'h7000 + i));
    check_eq("preflush_peak", 32'(peak), 7);
    flush = 1'b1; din = 16'hDEAD; din_valid = 1'b1;
    tick();
    flush = 1'b0; din_valid = 1'b0;
    check_eq("flush_level", 32'(lvl), 0);
    check_eq("flush_valid", 32'(dout_valid), 0);
    check_eq("flush_peak", 32'(peak), 7);
    check_eq("flush_ready", 32'(din_ready), 1);
    check_eq("flush_dout_hold", 32'(dout), 32'h7000);
    push_one(16'h1234);
    check_eq("postflush_dout", 32'(dout), 32'h1234);
    check_eq("postflush_level", 32'(lvl), 1);

    // Reset mid-burst
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 16'(16'h9000 + i);
      tick();
    end
    rst_n = 1'b0;
    tick();
    din_valid = 1'b0;
    check_eq("midrst_level", 32'(lvl), 0);
    check_eq("midrst_valid", 32'(dout_valid), 0);
    check_eq("midrst_dout", 32'(dout), 0);
    check_eq("midrst_ready", 32'(din_ready), 0);
    check_eq("midrst_peak", 32'(peak), 0);
    rst_n = 1'b1;
    tick();
    check_eq("midrst_release_ready", 32'(din_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_fwft_wm.md
Name: fifo_fwft_wm

Overview:
- Parametrised first-word-fall-through FIFO with registered output stage, for buffering body-state words between N-body pipeline stages.
- Generalises the team's 16-bit / 256-deep FIFO with:
  - configurable width and depth;
  - almost-full and almost-empty thresholds;
  - synchronous flush;
  - peak-occupancy watermark for sizing buffers in simulation and on silicon.
- Ready/valid on both sides.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 256, total capacity in words including output register; power of two, >= 4.
- ADDR_BITS, $clog2(DEPTH), storage pointer width.
- AFULL_THRESH, DEPTH-4, ALMOST_FULL asserts when level >= this; range 1..DEPTH.
- AEMPTY_THRESH, 2, ALMOST_EMPTY asserts when level <= this; range 0..DEPTH-1.

Ports:
- CLK_IN  in  1  single clock; all logic on rising edge.
- RESET_IN  in  1  synchronous, active-low reset.
- FLUSH_IN  in  1  synchronous clear of contents; active-high.
- CLR_PEAK_IN  in  1  synchronous clear of PEAK_LEVEL; active-high.
- DIN  in  WIDTH  write data.
- DIN_VALID  in  1  write request.
- DIN_READY  out  1  FIFO can accept a word this cycle.
- DOUT  out  WIDTH  head-of-FIFO data (registered).
- DOUT_VALID  out  1  DOUT holds a valid word.
- DOUT_READY  in  1  consumer accepts DOUT.
- level  out  ADDR_BITS+1  words held (storage + output register), 0..DEPTH.
- ALMOST_FULL  out  1  level >= AFULL_THRESH.
- ALMOST_EMPTY  out  1  level <= AEMPTY_THRESH.
- PEAK_LEVEL  out  ADDR_BITS+1  maximum level since reset/clear.

Behaviour:
- Reset (RESET_IN low at a rising edge):
  - level=0, DOUT_VALID=0, DOUT=0, PEAK_LEVEL=0, DIN_READY=0, pointers=0.
  - Reset has priority over everything.
  - DIN_READY becomes 1 at the first edge with RESET_IN high.
  - Reset mid-transfer discards all data.
- Push: accepted at an edge where DIN_VALID && DIN_READY. Pop: occurs at an edge where DOUT_VALID && DOUT_READY.
- DIN_READY is a registered copy of (next level < DEPTH). It never depends combinationally on DOUT_READY.
  - When full, a simultaneous pop does not admit a push that cycle.
  - DIN_READY returns to 1 the cycle after the pop.
- Push to empty FIFO (level 0): word loads directly into the output register. DOUT_VALID=1 and DOUT=word in the cycle after the accepting edge (1-cycle latency).
- Output refill after pop:
  - If storage is non-empty, the output register reloads from storage at the same edge; DOUT_VALID stays 1, with no bubble.
  - If storage is empty and a push coincides, the pushed word bypasses into the output register; DOUT_VALID stays 1.
  - Otherwise DOUT_VALID falls to 0 and DOUT holds its last value.
- DOUT and DOUT_VALID are stable while DOUT_VALID && !DOUT_READY.
- Ordering is strict FIFO across wrap-around. Storage pointers wrap modulo DEPTH-1 slots plus the output register, or equivalent; the only observable requirement is ordering and capacity DEPTH.
- level per edge:
  - +1 on push only; -1 on pop only; unchanged on push+pop or idle.
  - Never exceeds DEPTH and never underflows.
- ALMOST_FULL and ALMOST_EMPTY are combinational from the registered level, so they update in the same cycle as level.
- FLUSH_IN high at an edge (RESET_IN high):
  - level=0, DOUT_VALID=0, pointers=0.
  - Any push or pop that cycle is ignored.
  - DIN_READY=1 at the next cycle; DOUT keeps its value.
  - PEAK_LEVEL is unaffected.
- PEAK_LEVEL: registered.
  - Updates to next level when next level > PEAK_LEVEL.
  - CLR_PEAK_IN loads the current next level. It does not load 0 unless the FIFO is empty.
- No X propagation from the uninitialised memory array. DOUT is only ever loaded from written entries or DIN.

Test Plan (DEPTH=16, WIDTH=16, AFULL_THRESH=12, AEMPTY_THRESH=2):
- Reset, then a single push of 16'hAAAA, DOUT_READY=0 -> next cycle DOUT_VALID=1, DOUT=16'hAAAA, level=1, ALMOST_EMPTY=1. Pop -> DOUT_VALID=0, level=0.
- Push 0..15 back-to-back, no pops:
  - ALMOST_FULL rises when level=12.
  - After the 16th push, level=16 and DIN_READY=0; a 17th DIN_VALID is not accepted.
  - Then pop 16 with DOUT_READY held high -> DOUT = 0..15 in order, one per cycle, no bubbles. DOUT_VALID=0 after the last pop; PEAK_LEVEL=16.
- Full FIFO, DIN_VALID=1 and DOUT_READY=1 in the same cycle -> pop occurs, push not accepted, level=15. DIN_READY=1 the next cycle; the held word is accepted then.
- level=1 (16'h1111), simultaneous push 16'h2222 and pop -> level stays 1, DOUT_VALID stays 1, DOUT=16'h2222 the next cycle.
- Wrap: 40 pushes interleaved with pops, keeping level between 3 and 9 -> output sequence matches input exactly; PEAK_LEVEL=9. CLR_PEAK_IN at level 5 -> PEAK_LEVEL=5.
- level=7, FLUSH_IN with concurrent push -> level=0, DOUT_VALID=0, pushed word discarded, PEAK_LEVEL unchanged. RESET_IN low mid-burst -> all outputs at reset values the next cycle.
